// File: rtl/seg_scan4.sv
// Four-digit multiplexed seven-segment scan driver with per-frame shadow
// registers, anti-ghost blanking, leading-zero suppression and pin polarity.
module seg_scan4 #(
  parameter int SLOT_CYCLES  = 4,
  parameter int BLANK_CYCLES = 1,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic        CLK_in,
  input  logic        RST,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp,
  input  logic        lz_blank,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame_done
);

  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   val_q;
  logic [3:0]    en_q;
  logic [3:0]    dp_q;
  logic          lz_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_out_q, dp_out_d;
  logic          fd_q, fd_d;

  logic          last_slot;
  logic          frame_end;
  logic          in_blank;
  logic          lit;
  logic [3:0]    nib;
  logic [3:0]    zero_above;
  logic [3:0]    an_l;
  logic [6:0]    seg_l;
  logic          dp_l;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b0111111;
      4'h1: decode = 7'b0000110;
      4'h2: decode = 7'b1011011;
      4'h3: decode = 7'b1001111;
      4'h4: decode = 7'b1100110;
      4'h5: decode = 7'b1101101;
      4'h6: decode = 7'b1111101;
      4'h7: decode = 7'b0000111;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1101111;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b1111100;
      4'hC: decode = 7'b0111001;
      4'hD: decode = 7'b1011110;
      4'hE: decode = 7'b1111001;
      default: decode = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    last_slot = (cnt_q == CNT_LAST);
    frame_end = last_slot && (idx_q == 2'd3);
    in_blank  = int'(cnt_q) < BLANK_CYCLES;
    nib       = 4'(val_q >> {idx_q, 2'b00});

    // zero_above[i]: digit i and every digit above it show nothing worth keeping
    zero_above[3] = (val_q[15:12] == 4'h0) && !dp_q[3];
    zero_above[2] = zero_above[3] && (val_q[11:8] == 4'h0) && !dp_q[2];
    zero_above[1] = zero_above[2] && (val_q[7:4] == 4'h0) && !dp_q[1];
    zero_above[0] = zero_above[1] && (val_q[3:0] == 4'h0) && !dp_q[0];
    lit = en_q[idx_q] && !(lz_q && (idx_q != 2'd0) && zero_above[idx_q]);

    an_l  = 4'h0;
    seg_l = 7'h00;
    dp_l  = 1'b0;
    if (!in_blank && lit) begin
      an_l[idx_q] = 1'b1;
      seg_l       = decode(nib);
      dp_l        = dp_q[idx_q];
    end

    an_d     = ACTIVE_LOW ? ~an_l  : an_l;
    seg_d    = ACTIVE_LOW ? ~seg_l : seg_l;
    dp_out_d = ACTIVE_LOW ? ~dp_l  : dp_l;
    fd_d     = frame_end;

    cnt_d = last_slot ? '0 : cnt_q + 1'b1;
    idx_d = last_slot ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge CLK_in) begin
    if (RST) begin
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_out_q <= DP_OFF;
      fd_q     <= 1'b0;
      val_q    <= value;
      en_q     <= digit_en;
      dp_q     <= dp;
      lz_q     <= lz_blank;
    end else begin
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
      fd_q     <= fd_d;
      // Reload only at the frame boundary so a whole frame shows one value
      if (frame_end) begin
        val_q <= value;
        en_q  <= digit_en;
        dp_q  <= dp;
        lz_q  <= lz_blank;
      end
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_out_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Bench for seg_scan4: default build (4/1/active-low) and a 2/0/active-high
// build side by side, both checked against a position-based display model.
module tb_seg_scan4;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp;
  logic        lz_blank;

  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic        fd_a, fd_b;

  int checks = 0;
  int errors = 0;

  seg_scan4 dut_a (
    .CLK_in(clk), .RST(rst), .value(value), .digit_en(digit_en), .dp(dp),
    .lz_blank(lz_blank), .AN(an_a), .SEG(seg_a), .DP(dp_a), .frame_done(fd_a)
  );

  seg_scan4 #(.SLOT_CYCLES(2), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b0)) dut_b (
    .CLK_in(clk), .RST(rst), .value(value), .digit_en(digit_en), .dp(dp),
    .lz_blank(lz_blank), .AN(an_b), .SEG(seg_b), .DP(dp_b), .frame_done(fd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: output is a function of the cycle position since reset
  logic [6:0] seg_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic logic [12:0] model_out(input int pos, input logic [15:0] v,
      input logic [3:0] en, input logic [3:0] dpv, input logic lz,
      input int s, input int b, input bit al);
    int d, c;
    logic [3:0] an, nib;
    logic [6:0] sg;
    logic dd, fd, lit;
    d   = (pos / s) % 4;
    c   = pos % s;
    an  = 4'h0;
    sg  = 7'h00;
    dd  = 1'b0;
    nib = v[4*d +: 4];
    fd  = (pos % (4 * s)) == (4 * s - 1);
    lit = en[d] && !(lz && d >= 1 && (v >> (4 * d)) == 16'h0 && (dpv >> d) == 4'h0);
    if (c >= b && lit) begin
      an[d] = 1'b1;
      sg    = seg_tab[nib];
      dd    = dpv[d];
    end
    if (al) return {~an, ~sg, ~dd, fd};
    return {an, sg, dd, fd};
  endfunction

  int          pos_a, pos_b;
  logic [15:0] shv_a, shv_b;
  logic [3:0]  she_a, she_b, shd_a, shd_b;
  logic        shl_a, shl_b;
  logic [12:0] exp_a, exp_b;

  always @(posedge clk) begin
    if (rst) begin
      exp_a <= {4'hF, 7'h7F, 1'b1, 1'b0};
      exp_b <= 13'h0;
      pos_a <= 0;
      pos_b <= 0;
      shv_a <= value; she_a <= digit_en; shd_a <= dp; shl_a <= lz_blank;
      shv_b <= value; she_b <= digit_en; shd_b <= dp; shl_b <= lz_blank;
    end else begin
      exp_a <= model_out(pos_a, shv_a, she_a, shd_a, shl_a, 4, 1, 1'b1);
      exp_b <= model_out(pos_b, shv_b, she_b, shd_b, shl_b, 2, 0, 1'b0);
      pos_a <= pos_a + 1;
      pos_b <= pos_b + 1;
      if (pos_a % 16 == 15) begin
        shv_a <= value; she_a <= digit_en; shd_a <= dp; shl_a <= lz_blank;
      end
      if (pos_b % 8 == 7) begin
        shv_b <= value; she_b <= digit_en; shd_b <= dp; shl_b <= lz_blank;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; value = 16'h1234; digit_en = 4'hF; dp = 4'h0; lz_blank = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (an_a !== 4'hF || seg_a !== 7'h7F || dp_a !== 1'b1 || fd_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_a: got %h/%h/%b/%b exp f/7f/1/0", an_a, seg_a, dp_a, fd_a);
      end
      checks++;
      if (an_b !== 4'h0 || seg_b !== 7'h00 || dp_b !== 1'b0 || fd_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_b: got %h/%h/%b/%b exp 0/00/0/0", an_b, seg_b, dp_b, fd_b);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    int pulses = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checks++;
      if ({an_a, seg_a, dp_a, fd_a} !== exp_a) begin
        errors++;
        $display("FAIL scan_a k=%0d: got %h exp %h", k, {an_a, seg_a, dp_a, fd_a}, exp_a);
      end
      checks++;
      if ({an_b, seg_b, dp_b, fd_b} !== exp_b) begin
        errors++;
        $display("FAIL scan_b k=%0d: got %h exp %h", k, {an_b, seg_b, dp_b, fd_b}, exp_b);
      end
      if (fd_a === 1'b1) pulses++;
      if (k % 16 == 0) begin
        checks++;
        if (an_a !== 4'hF) begin
          errors++;
          $display("FAIL scan_blank k=%0d: got AN %h exp f", k, an_a);
        end
      end
      if (k % 16 >= 1 && k % 16 <= 3) begin
        checks++;
        if (an_a !== 4'b1110 || seg_a !== 7'b0011001) begin
          errors++;
          $display("FAIL scan_digit0 k=%0d: got %b/%b exp 1110/0011001", k, an_a, seg_a);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL frame_done_count: got %0d exp 2", pulses);
    end
  endtask

  task automatic test_tear();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checks++;
      if ({an_a, seg_a, dp_a, fd_a} !== exp_a) begin
        errors++;
        $display("FAIL tear_a k=%0d: got %h exp %h", k, {an_a, seg_a, dp_a, fd_a}, exp_a);
      end
      checks++;
      if ({an_b, seg_b, dp_b, fd_b} !== exp_b) begin
        errors++;
        $display("FAIL tear_b k=%0d: got %h exp %h", k, {an_b, seg_b, dp_b, fd_b}, exp_b);
      end
      if (k >= 13 && k <= 15) begin
        checks++;
        if (seg_a !== 7'b1111001) begin
          errors++;
          $display("FAIL tear_old k=%0d: got %b exp 1111001", k, seg_a);
        end
      end
      if (k >= 29) begin
        checks++;
        if (seg_a !== 7'b0001000) begin
          errors++;
          $display("FAIL tear_new k=%0d: got %b exp 0001000", k, seg_a);
        end
      end
      if (k == 5) value = 16'hABCD;
    end
  endtask

  task automatic test_lz();
    value = 16'h0050; lz_blank = 1'b1; dp = 4'h0;
    for (int k = 0; k < 64; k++) begin
      if (k == 32) dp = 4'b0100;
      @(negedge clk);
      checks++;
      if ({an_a, seg_a, dp_a, fd_a} !== exp_a) begin
        errors++;
        $display("FAIL lz_a k=%0d: got %h exp %h", k, {an_a, seg_a, dp_a, fd_a}, exp_a);
      end
      checks++;
      if ({an_b, seg_b, dp_b, fd_b} !== exp_b) begin
        errors++;
        $display("FAIL lz_b k=%0d: got %h exp %h", k, {an_b, seg_b, dp_b, fd_b}, exp_b);
      end
      if (k >= 21 && k <= 23) begin
        checks++;
        if (an_a !== 4'b1101 || seg_a !== 7'b0010010) begin
          errors++;
          $display("FAIL lz_digit1 k=%0d: got %b/%b exp 1101/0010010", k, an_a, seg_a);
        end
      end
      if ((k >= 24 && k <= 31) || (k >= 60)) begin
        checks++;
        if (an_a !== 4'hF) begin
          errors++;
          $display("FAIL lz_dark k=%0d: got AN %b exp 1111", k, an_a);
        end
      end
      if (k >= 57 && k <= 59) begin
        checks++;
        if (an_a !== 4'b1011 || seg_a !== 7'b1000000 || dp_a !== 1'b0) begin
          errors++;
          $display("FAIL lz_dp k=%0d: got %b/%b/%b exp 1011/1000000/0", k, an_a, seg_a, dp_a);
        end
      end
    end
  endtask

  task automatic test_digit_en();
    value = 16'h8888; digit_en = 4'b0101; dp = 4'h0; lz_blank = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checks++;
      if ({an_a, seg_a, dp_a, fd_a} !== exp_a) begin
        errors++;
        $display("FAIL en_a k=%0d: got %h exp %h", k, {an_a, seg_a, dp_a, fd_a}, exp_a);
      end
      checks++;
      if ({an_b, seg_b, dp_b, fd_b} !== exp_b) begin
        errors++;
        $display("FAIL en_b k=%0d: got %h exp %h", k, {an_b, seg_b, dp_b, fd_b}, exp_b);
      end
      if (k >= 16) begin
        checks++;
        if (an_a[1] !== 1'b1 || an_a[3] !== 1'b1 || an_b[1] !== 1'b0 || an_b[3] !== 1'b0 ||
            (an_a !== 4'hF && seg_a !== 7'h00)) begin
          errors++;
          $display("FAIL en_mask k=%0d: got a=%b/%b b=%b", k, an_a, seg_a, an_b);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    digit_en = 4'hF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if ((pos_a / 4) % 4 == 2) break;
    end
    rst = 1'b1;
    value = 16'($urandom_range(1, 16'hFFFF)); dp = 4'($urandom_range(0, 15)); lz_blank = 1'b0;
    @(negedge clk);
    checks++;
    if (an_a !== 4'hF || seg_a !== 7'h7F || dp_a !== 1'b1 || fd_a !== 1'b0 ||
        an_b !== 4'h0 || seg_b !== 7'h00 || dp_b !== 1'b0 || fd_b !== 1'b0) begin
      errors++;
      $display("FAIL midreset_off: got a=%h/%h/%b/%b b=%h/%h/%b/%b", an_a, seg_a, dp_a,
               fd_a, an_b, seg_b, dp_b, fd_b);
    end
    rst = 1'b0;
    value = 16'h0000;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checks++;
      if ({an_a, seg_a, dp_a, fd_a} !== exp_a) begin
        errors++;
        $display("FAIL midreset_a k=%0d: got %h exp %h", k, {an_a, seg_a, dp_a, fd_a}, exp_a);
      end
      checks++;
      if ({an_b, seg_b, dp_b, fd_b} !== exp_b) begin
        errors++;
        $display("FAIL midreset_b k=%0d: got %h exp %h", k, {an_b, seg_b, dp_b, fd_b}, exp_b);
      end
      if (k >= 1 && k <= 3) begin
        checks++;
        if (an_a !== 4'b1110) begin
          errors++;
          $display("FAIL midreset_restart k=%0d: got AN %b exp 1110", k, an_a);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      checks++;
      if ({an_a, seg_a, dp_a, fd_a} !== exp_a) begin
        errors++;
        $display("FAIL rand_a k=%0d: got %h exp %h", k, {an_a, seg_a, dp_a, fd_a}, exp_a);
      end
      checks++;
      if ({an_b, seg_b, dp_b, fd_b} !== exp_b) begin
        errors++;
        $display("FAIL rand_b k=%0d: got %h exp %h", k, {an_b, seg_b, dp_b, fd_b}, exp_b);
      end
      checks++;
      if ($countones(~an_a) > 1 || $countones(an_b) > 1) begin
        errors++;
        $display("FAIL rand_onehot k=%0d: got a=%b b=%b exp at most one active", k, an_a, an_b);
      end
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int n = 0; n < 4; n++)
          value[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        digit_en = 4'($urandom_range(0, 15));
        dp       = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        lz_blank = 1'($urandom_range(0, 1));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear();
    test_lz();
    test_digit_en();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan4.md
Name: seg_scan4

Overview:
- Four-digit multiplexed seven-segment scan driver for the FourDigitPlus display path.
- Clocked by the slow scan clock produced by the clock divider upstream.
- Takes the adder's 16-bit hex/BCD result and drives anode and segment lines one digit at a time.
- Shadow registers are loaded once per frame, so a result changing mid-scan never tears the display.

Parameters:
- SLOT_CYCLES, 4, scan-clock cycles each digit owns per frame; must be ≥2.
- BLANK_CYCLES, 1, leading cycles of each slot with all anodes off (anti-ghosting); 0 ≤ BLANK_CYCLES < SLOT_CYCLES.
- ACTIVE_LOW, 1, 1 = AN/SEG/DP pins active-low; 0 = active-high.

Ports:
- CLK_in  input  1  scan clock (divided clock); all logic on its rising edge.
- RST  input  1  synchronous reset, active-high.
- value  input  16  four nibbles; value[3:0] is digit 0 (rightmost), value[15:12] is digit 3.
- digit_en  input  4  per-digit enable; 0 = digit dark for the whole slot.
- dp  input  4  per-digit decimal point request.
- lz_blank  input  1  1 = suppress leading zeros.
- AN  output  4  digit select; AN[i] drives digit i.
- SEG  output  7  {g,f,e,d,c,b,a}.
- DP  output  1  decimal point segment.
- frame_done  output  1  one-cycle pulse in the last output cycle of each frame.

Behaviour:
- One clock, synchronous active-high reset, no other clock domain.
- Reset (RST=1 at an edge):
  - idx←0, cnt←0.
  - AN, SEG, DP all inactive (pin level 1 when ACTIVE_LOW=1); frame_done←0.
  - Shadow registers (value, digit_en, dp, lz_blank) load the inputs on every reset edge.
- Counters:
  - cnt counts 0..SLOT_CYCLES-1 and wraps to 0.
  - On wrap, idx increments 0→1→2→3→0.
- Shadow reload:
  - Shadows reload on the edge where idx=3 and cnt=SLOT_CYCLES-1, so the next frame's digit 0 uses new data.
  - Input changes at any other time have no visible effect until the next reload.
- Outputs are registered, one cycle latency. Output values after edge t are f(idx, cnt, shadows) as held before edge t.
  - After the first edge with RST=0, the outputs show digit 0 cnt 0.
- Slot content for digit i = idx:
  - While cnt < BLANK_CYCLES: all AN inactive, SEG and DP inactive.
  - Otherwise, if digit i is lit: AN[i] active, other AN inactive, SEG = decode(nibble i), DP = dp[i].
  - Otherwise (digit i not lit): all AN inactive, SEG and DP inactive.
- "Lit" rule:
  - Requires digit_en[i]=1.
  - If lz_blank=1 and i≥1, additionally requires that NOT (nibbles i..3 all zero AND dp[i..3] all zero).
  - Digit 0 is never leading-zero blanked.
- Decode is logical, active-high, {g..a}, full hex:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - When ACTIVE_LOW=1, AN, SEG and DP pins are the bitwise inverse of the logical values.
- frame_done is 1 exactly in the output cycle of digit 3, cnt=SLOT_CYCLES-1; otherwise 0.
- Frame length is 4·SLOT_CYCLES cycles; no gaps between frames.
- Reset mid-frame: on the next edge, outputs go inactive, counters return to 0, shadows reload; scanning restarts at digit 0.
- Simultaneous value change and reload edge: the value sampled at that edge is the one displayed in the next frame.
- At most one AN bit is active in any cycle; no cycle ever has two digits on.

Test Plan:
- Reset sequence: RST=1 for 3 cycles, then 0; value=16'h1234, digit_en=4'hF, lz_blank=0, defaults.
  - AN=4'hF and SEG=7'h7F during reset.
  - Then repeating 16-cycle frame:
    - digit 0: 1 blank cycle, then 3 cycles AN=4'b1110, SEG=~0000110 ("4" is digit0? no: value[3:0]=4, so SEG=~1100110).
    - digit 1: "3".
    - digit 2: "2".
    - digit 3: "1".
  - frame_done pulses once per 16 cycles.
- Tear-free update: change value to 16'hABCD at cycle 5 of a frame.
  - Current frame still shows 1,2,3,4.
  - Next frame shows d,C,b,A (digit0..3).
- Leading-zero blanking: value=16'h0050, lz_blank=1, dp=0.
  - Digits 3 and 2 dark; digit 1 shows "5"; digit 0 shows "0".
  - With dp=4'b0100: digit 2 shows "0" with DP on; digit 3 stays dark.
- digit_en=4'b0101, value=16'h8888: only AN[0] and AN[2] are ever active, SEG=~7'h7F when active.
- Mid-frame reset: assert RST for 1 cycle at idx=2.
  - Next cycle all outputs are inactive.
  - Scan restarts at digit 0 with the inputs sampled during reset.
- Parameter sweep: SLOT_CYCLES=2, BLANK_CYCLES=0, ACTIVE_LOW=0.
  - 8-cycle frame, no blank cycles.
  - Active-high pins; one-hot AN every cycle for lit digits.
